// File: rtl/ascon_perm_arbiter_pkg.sv
// Shared definitions for the masked Ascon permutation arbiter: FSM encoding,
// round-count limits and the core control bundle.
package ascon_perm_arbiter_pkg;

  localparam int unsigned STATE_W    = 320;
  localparam int unsigned ROUNDS_MAX = 12;
  localparam int unsigned ROUND_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic sel1;
    logic sel2;
    logic sel_cst;
    logic done;
  } core_ctrl_t;

  // Zero and anything above the maximum both mean a full-length permutation.
  function automatic logic [ROUND_W-1:0] clamp_rounds(input logic [ROUND_W-1:0] r);
    if (r == '0 || r > ROUND_W'(ROUNDS_MAX)) begin
      return ROUND_W'(ROUNDS_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_perm_arbiter_rr_arbiter.sv
// N_REQ-wide round-robin grant; the search starts at the priority pointer,
// which moves just past the winner whenever a grant is taken.
module ascon_perm_arbiter_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_valid_c
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!grant_valid_c && req[cand]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx_c == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ascon_perm_arbiter.sv
// Shares one masked Ascon permutation core between N_REQ requesters: accepts a
// job, sequences R rounds of CYC_PER_ROUND cycles, then holds the result.
module ascon_perm_arbiter
  import ascon_perm_arbiter_pkg::*;
#(
  parameter int unsigned D             = 2,
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned CYC_PER_ROUND = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*STATE_W*D-1:0]   req_state,
  input  logic [N_REQ*ROUND_W-1:0]     req_rounds,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [STATE_W*D-1:0]         rsp_state,
  output logic                         core_sel1,
  output logic                         core_sel2,
  output logic                         core_sel_cst,
  output logic                         core_done,
  output logic [STATE_W*D-1:0]         core_state_in,
  input  logic [STATE_W*D-1:0]         core_state_out,
  output logic                         busy
);

  localparam int unsigned SW    = STATE_W * D;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CYC_W = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;

  logic [N_REQ-1:0]   grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               grant_valid_c;
  logic               accept;
  logic [SW-1:0]      sel_state;
  logic [ROUND_W-1:0] sel_rounds;
  logic               last_cyc;
  logic               last_round;
  core_ctrl_t         ctrl;

  ascon_perm_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) rr_arbiter (
    .clk           (clk),
    .rst           (rst),
    .req           (req_valid),
    .advance       (accept),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // One-hot grant selects the winner's state and round count.
  always_comb begin
    sel_state  = '0;
    sel_rounds = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_state  = sel_state  | req_state[i*SW +: SW];
        sel_rounds = sel_rounds | req_rounds[i*ROUND_W +: ROUND_W];
      end
    end
  end

  assign last_cyc   = (cycle_cnt_q == CYC_W'(CYC_PER_ROUND - 1));
  assign last_round = (round_cnt_q == rounds_q - ROUND_W'(1));

  // Next-state and outputs; acceptance is suppressed while rst is held.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rounds_d      = rounds_q;
    cycle_cnt_d   = cycle_cnt_q;
    round_cnt_d   = round_cnt_q;
    ctrl          = '0;
    accept        = 1'b0;
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_state     = '0;
    core_state_in = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c && !rst) begin
          accept        = 1'b1;
          req_ready     = grant_c;
          ctrl.sel1     = 1'b1;
          ctrl.sel2     = 1'b1;
          core_state_in = sel_state;
          owner_d       = grant_idx_c;
          rounds_d      = clamp_rounds(sel_rounds);
          cycle_cnt_d   = '0;
          round_cnt_d   = '0;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        ctrl.sel_cst = (cycle_cnt_q == '0);
        if (last_cyc) begin
          ctrl.sel2   = 1'b1;
          cycle_cnt_d = '0;
          if (last_round) begin
            ctrl.done   = 1'b1;
            round_cnt_d = '0;
            state_d     = ST_RESP;
          end else begin
            round_cnt_d = round_cnt_q + ROUND_W'(1);
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid = N_REQ'(1) << owner_q;
        rsp_state = core_state_out;
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rounds_q    <= '0;
      cycle_cnt_q <= '0;
      round_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rounds_q    <= rounds_d;
      cycle_cnt_q <= cycle_cnt_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign core_sel1    = ctrl.sel1;
  assign core_sel2    = ctrl.sel2;
  assign core_sel_cst = ctrl.sel_cst;
  assign core_done    = ctrl.done;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/ascon_perm_arbiter.md
ASCON_PERM_ARBITER -- requirements
Module: ascon_perm_arbiter

Interface
REQ-001 Parameter D, default 2: masking order (shares per state bit).
REQ-002 Parameter N_REQ, default 2: number of requesters sharing one masked permutation core.
REQ-003 Parameter CYC_PER_ROUND, default 6: core cycles per round.
REQ-004 clk  in  1: clock. rst  in  1: reset, synchronous, active-high.
REQ-005 req_valid  in  N_REQ: requester i has a permutation job pending.
REQ-006 req_ready  out  N_REQ: one-hot, pulses for one cycle when the job is accepted.
REQ-007 req_state  in  N_REQ*320*D: masked input state per requester; slice i = bits [i*320*D +: 320*D].
REQ-008 req_rounds  in  N_REQ*4: round count per requester; legal values 1..12.
REQ-009 rsp_valid  out  N_REQ: one-hot, result available for the owning requester.
REQ-010 rsp_ready  in  N_REQ: requester i consumes its result.
REQ-011 rsp_state  out  320*D: masked result, valid while any rsp_valid bit is high.
REQ-012 core_sel1, core_sel2, core_sel_cst, core_done  out  1 each: permutation core controls.
REQ-013 core_state_in  out  320*D: load value for the core. core_state_out  in  320*D: core state.
REQ-014 busy  out  1: high in every state except IDLE.

Function
REQ-015 FSM states are IDLE, RUN and RESP; no other states exist.
REQ-016 In IDLE, with any req_valid high, the arbiter accepts exactly one requester in that same cycle, asserts its req_ready bit, drives core_sel1=core_sel2=1 and core_state_in=its req_state slice, latches owner index and round count, and moves to RUN.
REQ-017 Arbitration is round-robin: search starts at priority pointer p; after a grant to i, p becomes (i+1) mod N_REQ.
REQ-018 A req_rounds value of 0 or greater than 12 is clamped to 12.
REQ-019 In RUN, cycle_cnt counts 0..CYC_PER_ROUND-1. core_sel_cst=1 when cycle_cnt=0, core_sel2=1 when cycle_cnt=CYC_PER_ROUND-1, and round_cnt increments at that cycle while cycle_cnt wraps to 0.
REQ-020 On the last cycle of round R-1, where R is the latched round count, core_done=1 and the FSM moves to RESP.
REQ-021 In RESP, rsp_valid[owner]=1 and rsp_state=core_state_out, held stable until rsp_ready[owner]; the FSM then moves to IDLE in the next cycle.
REQ-022 Latency: with acceptance in cycle t, core_done is high at t+R*CYC_PER_ROUND and rsp_valid rises at t+R*CYC_PER_ROUND+1.
REQ-023 rsp_ready bits of non-owners are ignored. req_valid is ignored outside IDLE, and no req_ready is asserted there.
REQ-024 A requester dropping req_valid before acceptance is not an error; nothing is latched for it.
REQ-025 In RESP, core_sel1, core_sel2, core_sel_cst and core_done are held at 0 so that the core state is frozen.
REQ-026 In every cycle other than an acceptance cycle, core_state_in is all-zero.
REQ-027 No back-to-back acceptance occurs: the earliest next grant is the IDLE cycle following the rsp handshake.

Reset
REQ-028 rst takes effect at any time, including mid-RUN or mid-RESP. It forces IDLE, p=0, cycle_cnt=0 and round_cnt=0, and the owner is cleared.
REQ-029 Out of reset, every output is 0: req_ready, rsp_valid, rsp_state, all core_* outputs and busy. An aborted job produces no response.

Structure
REQ-030 FSM state encodings, the default ROUNDS_MAX=12 and the round-count width belong in the shared ascon package.
REQ-031 A single sub-module, rr_arbiter (N_REQ-wide round-robin grant with pointer update), is instantiated. The round and cycle counters stay in the top module.

Verification
REQ-032 Single requester 0, req_rounds=12, rsp_ready=1: req_ready[0] is high at t; core_done is high at t+72; rsp_valid[0] rises at t+73; rsp_state equals core_state_out.
REQ-033 Both requesters valid continuously from reset: grants alternate 0,1,0,1, each separated by a full job plus handshake.
REQ-034 req_rounds=6, then 0, then 15: core_done occurs 36, 72 and 72 cycles after acceptance respectively.
REQ-035 rsp_ready held low for 20 cycles in RESP: rsp_valid and rsp_state stay stable, core controls stay 0, and no new grant occurs.
REQ-036 rst at round 5 of a job: the next cycle shows IDLE with all outputs 0; the pending requester is re-granted with p=0 ordering.
REQ-037 Self-checking model: the core is modelled as an unmasked Ascon reference permutation on XOR-recombined shares. The recombined rsp_state matches p^R(recombined req_state) for random states, with R in 1..12.
